// File: rtl/wm8731_cfg_seq.sv
// -----------------------------------------------------------------------------
// wm8731_cfg_seq
// Register-table sequencer for the WM8731 codec. It sits directly in front of
// the I2C write engine. The sequencer works through a fixed table of codec
// register writes, one write at a time. For each write it:
//   - presents {DEV_ADDR, table[cfg_index]},
//   - frames the engine's start level,
//   - waits for end-of-transfer and checks the acknowledge.
// It then advances to the next entry, retries the same entry, or stops. The
// result is reported to the audio control logic as done or error levels.
//
// Optional build macro: CFG_RETRY_EN
//   defined   - a NACK or timeout retries the same entry up to MAX_RETRY
//               extra times before giving up (FAIL).
//   undefined - any NACK or timeout goes straight to FAIL.
//
// Ports:
//   clock_i2c  in   transfer clock, shared with the write engine
//   reset_n    in   asynchronous active-low reset
//   go         in   restart request, honoured only in DONE or FAIL
//   tr_end     in   end-of-transfer level from the engine
//   ack        in   OR of the engine's ack samples (1 = NACK)
//   i2c_data   out  24-bit word for the engine, stable while start is high
//   start      out  engine enable (low holds the engine at cycle 0)
//   cfg_index  out  current table entry
//   cfg_done   out  all entries written successfully (level)
//   cfg_error  out  an entry failed; cfg_index holds that entry (level)
// -----------------------------------------------------------------------------
module wm8731_cfg_seq #(
   parameter logic [7:0] DEV_ADDR   = 8'h34,
   parameter int         NUM_REGS   = 10,
   parameter int         GAP_CYCLES = 4,
   parameter int         TIMEOUT    = 63,
   parameter int         MAX_RETRY  = 3
) (
   input  logic        clock_i2c,
   input  logic        reset_n,
   input  logic        go,
   input  logic        tr_end,
   input  logic        ack,
   output logic [23:0] i2c_data,
   output logic        start,
   output logic [3:0]  cfg_index,
   output logic        cfg_done,
   output logic        cfg_error
);

   // A gap shorter than 2 cycles may not let the engine drop tr_end.
   localparam int          GAP_EFF  = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
   localparam logic [15:0] GAP_LAST = 16'(GAP_EFF - 1);
   localparam logic [5:0]  TO_LAST  = 6'(TIMEOUT - 1);
   localparam logic [4:0]  NUM_R5   = 5'(NUM_REGS);

   typedef enum logic [2:0] {
      ST_GAP   = 3'd0,
      ST_XFER  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAIL  = 3'd4
   } state_t;

   state_t      state_q;
   logic        start_q;
   logic [3:0]  idx_q;
   logic        done_q;
   logic        err_q;
   logic [23:0] data_q;
   logic [15:0] gap_cnt_q;
   logic [5:0]  tmo_cnt_q;
   logic        nack_q;     // latched NACK or timeout of the last attempt
   logic [4:0]  idx_inc_d;  // 5 bits so the compare with NUM_REGS cannot wrap
`ifdef CFG_RETRY_EN
   localparam logic [7:0] MAX_R8 = 8'(MAX_RETRY);
   logic [7:0]  retry_q;
`endif

   // Codec register table (WM8731 register/data pairs).
   function automatic logic [15:0] table_word(input logic [3:0] idx);
      case (idx)
         4'd0:    table_word = 16'h1E00;  // software reset
         4'd1:    table_word = 16'h0017;
         4'd2:    table_word = 16'h0217;
         4'd3:    table_word = 16'h0479;
         4'd4:    table_word = 16'h0679;
         4'd5:    table_word = 16'h0810;
         4'd6:    table_word = 16'h0A00;
         4'd7:    table_word = 16'h0C00;
         4'd8:    table_word = 16'h0E01;
         4'd9:    table_word = 16'h1201;
         default: table_word = 16'h0000;
      endcase
   endfunction

   always_comb begin
      idx_inc_d = {1'b0, idx_q} + 5'd1;
   end

   always_ff @(posedge clock_i2c or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_GAP;
         start_q   <= 1'b0;
         idx_q     <= 4'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= {DEV_ADDR, table_word(4'd0)};
         gap_cnt_q <= 16'd0;
         tmo_cnt_q <= 6'd0;
         nack_q    <= 1'b0;
`ifdef CFG_RETRY_EN
         retry_q   <= 8'd0;
`endif
      end else begin
         case (state_q)
            ST_GAP: begin
               start_q <= 1'b0;
               if (gap_cnt_q == GAP_LAST) begin
                  state_q   <= ST_XFER;
                  start_q   <= 1'b1;
                  tmo_cnt_q <= 6'd0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 16'd1;
               end
            end

            ST_XFER: begin
               if (tr_end) begin
                  state_q <= ST_CHECK;
                  start_q <= 1'b0;
                  nack_q  <= ack;  // ack is final once tr_end is seen
               end else if (tmo_cnt_q == TO_LAST) begin
                  state_q <= ST_CHECK;
                  start_q <= 1'b0;
                  nack_q  <= 1'b1;  // a silent engine counts as a NACK
               end else if (tmo_cnt_q != 6'h3F) begin
                  tmo_cnt_q <= tmo_cnt_q + 6'd1;
               end
            end

            ST_CHECK: begin
               gap_cnt_q <= 16'd0;
               if (!nack_q) begin
`ifdef CFG_RETRY_EN
                  retry_q <= 8'd0;
`endif
                  if (idx_inc_d == NUM_R5) begin
                     // Keep cfg_index on the last entry instead of running past the table.
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_GAP;
                     idx_q   <= idx_inc_d[3:0];
                     data_q  <= {DEV_ADDR, table_word(idx_inc_d[3:0])};
                  end
               end else begin
`ifdef CFG_RETRY_EN
                  if (retry_q < MAX_R8) begin
                     // Resend the same entry; i2c_data is left untouched.
                     retry_q <= retry_q + 8'd1;
                     state_q <= ST_GAP;
                  end else begin
                     state_q <= ST_FAIL;
                     err_q   <= 1'b1;
                  end
`else
                  state_q <= ST_FAIL;
                  err_q   <= 1'b1;
`endif
               end
            end

            ST_DONE, ST_FAIL: begin
               start_q <= 1'b0;
               if (go) begin
                  state_q   <= ST_GAP;
                  done_q    <= 1'b0;
                  err_q     <= 1'b0;
                  idx_q     <= 4'd0;
                  data_q    <= {DEV_ADDR, table_word(4'd0)};
                  gap_cnt_q <= 16'd0;
`ifdef CFG_RETRY_EN
                  retry_q   <= 8'd0;
`endif
               end
            end

            default: begin
               state_q   <= ST_GAP;
               start_q   <= 1'b0;
               gap_cnt_q <= 16'd0;
            end
         endcase
      end
   end

   assign i2c_data  = data_q;
   assign start     = start_q;
   assign cfg_index = idx_q;
   assign cfg_done  = done_q;
   assign cfg_error = err_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_wm8731_cfg_seq
// Directed bench for wm8731_cfg_seq. A small engine model answers each
// transfer: it raises tr_end 3 cycles after start goes high. It NACKs a
// chosen word for a chosen number of attempts, or never ends the transfer
// when stuck is set. A monitor logs every transfer's word together with the
// low/high run lengths of start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wm8731_cfg_seq;

   logic        clock_i2c = 1'b0;
   logic        reset_n;
   logic        go = 1'b0;
   logic        tr_end = 1'b0;
   logic        ack = 1'b0;
   logic [23:0] i2c_data;
   logic        start;
   logic [3:0]  cfg_index;
   logic        cfg_done;
   logic        cfg_error;

   int err_cnt = 0;
   int chk_cnt = 0;

   localparam logic [23:0] EXP [10] = '{24'h341E00, 24'h340017, 24'h340217,
      24'h340479, 24'h340679, 24'h340810, 24'h340A00, 24'h340C00,
      24'h340E01, 24'h341201};

   wm8731_cfg_seq dut (
      .clock_i2c (clock_i2c),
      .reset_n   (reset_n),
      .go        (go),
      .tr_end    (tr_end),
      .ack       (ack),
      .i2c_data  (i2c_data),
      .start     (start),
      .cfg_index (cfg_index),
      .cfg_done  (cfg_done),
      .cfg_error (cfg_error)
   );

   always #5 clock_i2c = ~clock_i2c;

   // Engine model controls (written only by the stimulus block).
   logic        stuck = 1'b0;
   logic [23:0] nack_word = 24'h0;
   int          nack_until = 0;
   // Engine model state (written only by the engine block).
   int          eng_cnt = 0;
   int          nack_hits = 0;

   always @(negedge clock_i2c) begin
      if (!start) begin
         eng_cnt = 0;
         tr_end  = 1'b0;
         ack     = 1'b0;
      end else if (!tr_end) begin
         eng_cnt++;
         if (eng_cnt >= 3 && !stuck) begin
            tr_end = 1'b1;
            if (i2c_data == nack_word && nack_hits < nack_until) begin
               ack = 1'b1;
               nack_hits++;
            end else begin
               ack = 1'b0;
            end
         end
      end
   end

   // Transfer monitor.
   logic [23:0] xfers[$];
   int          lows[$];
   int          highs[$];
   logic        prev_start = 1'b0;
   int          low_run = 100;
   int          high_run = 0;

   always @(negedge clock_i2c) begin
      if (start && !prev_start) begin
         xfers.push_back(i2c_data);
         lows.push_back(low_run);
         high_run = 1;
      end else if (start) begin
         high_run++;
      end
      if (!start && prev_start) begin
         highs.push_back(high_run);
         low_run = 1;
      end else if (!start) begin
         low_run++;
      end
      prev_start = start;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic pulse_go();
      @(negedge clock_i2c); #1 go = 1'b1;
      @(negedge clock_i2c); #1 go = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (!(cfg_done || cfg_error) && n < budget) begin
         @(negedge clock_i2c); #1;
         n++;
      end
      check_val("end_within_budget", 32'(cfg_done | cfg_error), 32'd1);
   endtask

   task automatic wait_xfers(input int count, input int budget);
      int n = 0;
      while (xfers.size() < count && n < budget) begin
         @(negedge clock_i2c); #1;
         n++;
      end
      check_val("xfer_within_budget", 32'(xfers.size() >= count), 32'd1);
   endtask

   int base;
   int mn;

   initial begin
      // ---------------- reset state ----------------
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock_i2c);
      #1;
      check_val("rst_start", 32'(start), 32'd0);
      check_val("rst_index", 32'(cfg_index), 32'd0);
      check_val("rst_done", 32'(cfg_done), 32'd0);
      check_val("rst_error", 32'(cfg_error), 32'd0);
      check_val("rst_data", 32'(i2c_data), 32'h341E00);

      // ---------------- full table, all ACK ----------------
      @(negedge clock_i2c); reset_n = 1'b1;
      base = xfers.size();
      wait_end(2000);
      check_val("t1_done", 32'(cfg_done), 32'd1);
      check_val("t1_error", 32'(cfg_error), 32'd0);
      check_val("t1_index", 32'(cfg_index), 32'd9);
      check_val("t1_start", 32'(start), 32'd0);
      check_val("t1_count", 32'(xfers.size() - base), 32'd10);
      for (int i = 0; i < 10; i++)
         check_val($sformatf("t1_word%0d", i), 32'(xfers[base + i]), 32'(EXP[i]));
      mn = 1000;
      for (int i = base; i < lows.size(); i++) if (lows[i] < mn) mn = lows[i];
      check_val("t1_gap_ge4", 32'(mn >= 4), 32'd1);
      repeat (20) @(negedge clock_i2c);
      #1 check_val("t1_no_more", 32'(xfers.size() - base), 32'd10);

      // ---------------- go ignored in XFER, reset mid-XFER on entry 4 ----------------
      pulse_go();
      base = xfers.size();
      wait_xfers(base + 5, 500);
      go = 1'b1;                      // lands inside XFER of entry 4
      @(negedge clock_i2c); #1 go = 1'b0;
      check_val("t2_go_ign_idx", 32'(cfg_index), 32'd4);
      check_val("t2_go_ign_start", 32'(start), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_val("t2_rst_start", 32'(start), 32'd0);
      check_val("t2_rst_index", 32'(cfg_index), 32'd0);
      @(negedge clock_i2c); reset_n = 1'b1;
      wait_end(2000);
      check_val("t2_first_word", 32'(xfers[base + 5]), 32'h341E00);
      check_val("t2_count", 32'(xfers.size() - base), 32'd15);
      check_val("t2_done", 32'(cfg_done), 32'd1);

`ifdef CFG_RETRY_EN
      // ---------------- single NACK on entry 3 ----------------
      nack_word  = 24'h340479;
      nack_until = nack_hits + 1;
      pulse_go();
      base = xfers.size();
      wait_end(2000);
      check_val("t3_count", 32'(xfers.size() - base), 32'd11);
      check_val("t3_resent_a", 32'(xfers[base + 3]), 32'h340479);
      check_val("t3_resent_b", 32'(xfers[base + 4]), 32'h340479);
      check_val("t3_next", 32'(xfers[base + 5]), 32'h340679);
      check_val("t3_done", 32'(cfg_done), 32'd1);
      check_val("t3_error", 32'(cfg_error), 32'd0);

      // ---------------- persistent NACK on entry 5 ----------------
      nack_word  = 24'h340810;
      nack_until = nack_hits + 100;
      pulse_go();
      base = xfers.size();
      wait_end(2000);
      check_val("t4_count", 32'(xfers.size() - base), 32'd9);
      for (int i = 5; i < 9; i++)
         check_val($sformatf("t4_attempt%0d", i - 5), 32'(xfers[base + i]), 32'h340810);
      check_val("t4_error", 32'(cfg_error), 32'd1);
      check_val("t4_done", 32'(cfg_done), 32'd0);
      check_val("t4_index", 32'(cfg_index), 32'd5);
      check_val("t4_start", 32'(start), 32'd0);
      repeat (20) @(negedge clock_i2c);
      #1 check_val("t4_no_more", 32'(xfers.size() - base), 32'd9);
      nack_word = 24'h0;
`else
      // ---------------- NACK on entry 0, then restart ----------------
      nack_word  = 24'h341E00;
      nack_until = nack_hits + 1;
      pulse_go();
      base = xfers.size();
      wait_end(2000);
      check_val("t3_count", 32'(xfers.size() - base), 32'd1);
      check_val("t3_error", 32'(cfg_error), 32'd1);
      check_val("t3_done", 32'(cfg_done), 32'd0);
      check_val("t3_index", 32'(cfg_index), 32'd0);
      check_val("t3_start", 32'(start), 32'd0);
      repeat (20) @(negedge clock_i2c);
      #1 check_val("t3_no_more", 32'(xfers.size() - base), 32'd1);
      pulse_go();
      check_val("t3_err_clr", 32'(cfg_error), 32'd0);
      base = xfers.size();
      wait_end(2000);
      check_val("t3_restart_word", 32'(xfers[base]), 32'h341E00);
      check_val("t3_restart_count", 32'(xfers.size() - base), 32'd10);
      check_val("t3_restart_done", 32'(cfg_done), 32'd1);
      nack_word = 24'h0;
`endif

      // ---------------- tr_end stuck low: timeout ----------------
      stuck = 1'b1;
      pulse_go();
      base = xfers.size();
      wait_end(3000);
`ifdef CFG_RETRY_EN
      check_val("t5_count", 32'(xfers.size() - base), 32'd4);
`else
      check_val("t5_count", 32'(xfers.size() - base), 32'd1);
`endif
      check_val("t5_high_len", 32'(highs[highs.size() - 1]), 32'd63);
      check_val("t5_error", 32'(cfg_error), 32'd1);
      check_val("t5_index", 32'(cfg_index), 32'd0);
      check_val("t5_start", 32'(start), 32'd0);
      stuck = 1'b0;

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
